mpmc11_wr_burst: RTL and testbench

//  Write-data issue stage directly downstream of the PRESET2 write-data latch.

---
 rtl/mpmc11_pkg.sv | 15 +
 rtl/mpmc11_wr_burst_if.sv | 34 +++
 rtl/mpmc11_wr_burst.sv | 174 +++++++++++++++++
 tb/tb_mpmc11_wr_burst.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg -- shared types and constants for the MPMC11 write path.
//   wr_burst_state_t      : state encoding of the write-data burst FSM
//   MPMC11_WR_TO_DEFAULT  : default write-data timeout in controller clocks
package mpmc11_pkg;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_BEAT0,
    WB_BEAT1,
    WB_DONE
  } wr_burst_state_t;

  localparam int unsigned MPMC11_WR_TO_DEFAULT = 255;

endpackage

// File: rtl/mpmc11_wr_burst_if.sv
// mpmc11_wr_burst_if -- MIG app_wdf_* write-data FIFO bus.
//   app_wdf_rdy   : FIFO ready (slave -> master)
//   app_wdf_data  : write data, WID bits
//   app_wdf_mask  : byte mask, WID/8 bits, 1 = byte not written
//   app_wdf_wren  : write enable
//   app_wdf_end   : end-of-burst marker
// master modport : write-burst issue stage; slave modport : MIG / model.
interface mpmc11_wr_burst_if #(
  parameter int unsigned WID = 256
);

  logic                 app_wdf_rdy;
  logic [WID-1:0]       app_wdf_data;
  logic [(WID/8)-1:0]   app_wdf_mask;
  logic                 app_wdf_wren;
  logic                 app_wdf_end;

  modport master (
    input  app_wdf_rdy,
    output app_wdf_data,
    output app_wdf_mask,
    output app_wdf_wren,
    output app_wdf_end
  );

  modport slave (
    output app_wdf_rdy,
    input  app_wdf_data,
    input  app_wdf_mask,
    input  app_wdf_wren,
    input  app_wdf_end
  );

endinterface

// File: rtl/mpmc11_wr_burst.sv
// mpmc11_wr_burst -- write-data issue stage after the PRESET2 write-data latch.
// Sends the latched data words as a 1- or 2-beat burst on the MIG app_wdf_*
// interface, honouring app_wdf_rdy, and pulses done once the burst completes.
//
// Ports:
//   clk, rst_n        : ui_clk, asynchronous active-low reset
//   start             : 1-cycle pulse, sampled only when idle
//   single            : 1 = send dat1 only, 0 = dat1 then dat2
//   dat1/dat2         : beat 0 / beat 1 data (WID bits)
//   mask1/mask2       : beat 0 / beat 1 byte masks (WID/8 bits, 1 = not written)
//   wdf               : app_wdf_* bus (master modport)
//   busy              : burst in progress
//   done              : 1-cycle completion pulse
//   err               : sticky write-data timeout flag, cleared by next start
//
// Optional feature: define MPMC11_WR_TIMEOUT_EN to abort a burst stalled for
// TO_CYCLES clocks with rdy low; otherwise err is tied 0 and the FSM waits
// on rdy indefinitely.
module mpmc11_wr_burst
  import mpmc11_pkg::*;
#(
  parameter int unsigned WID       = 256,
  parameter int unsigned TO_CYCLES = MPMC11_WR_TO_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 single,
  input  logic [WID-1:0]       dat1,
  input  logic [WID-1:0]       dat2,
  input  logic [(WID/8)-1:0]   mask1,
  input  logic [(WID/8)-1:0]   mask2,
  mpmc11_wr_burst_if.master    wdf,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  wr_burst_state_t      state_q;
  logic [WID-1:0]       data_q;
  logic [(WID/8)-1:0]   mask_q;
  logic                 wren_q;
  logic                 end_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [WID-1:0]       dat2_q;
  logic [(WID/8)-1:0]   mask2_q;
  logic                 single_q;

  logic                 accept;
  logic                 in_beat;
  logic                 to_hit;

  always_comb begin
    accept  = wren_q & wdf.app_wdf_rdy;
    in_beat = (state_q == WB_BEAT0) || (state_q == WB_BEAT1);
  end

`ifdef MPMC11_WR_TIMEOUT_EN
  // Counter only needs to reach TO_CYCLES-1: the stalled edge seen at that
  // count is the TO_CYCLES-th one and triggers the abort.
  localparam int unsigned TOW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES);

  logic [TOW-1:0] cnt_q;

  always_comb begin
    to_hit = in_beat && !wdf.app_wdf_rdy && (cnt_q == TOW'(TO_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == WB_IDLE && start) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (in_beat) begin
        if (accept || to_hit) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + TOW'(1);
        end
        if (to_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_to_cycles;

  always_comb begin
    to_hit           = 1'b0;
    err_q            = 1'b0;
    unused_to_cycles = (TO_CYCLES != 0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WB_IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      wren_q   <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dat2_q   <= '0;
      mask2_q  <= '0;
      single_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WB_IDLE: begin
          if (start) begin
            dat2_q   <= dat2;
            mask2_q  <= mask2;
            single_q <= single;
            data_q   <= dat1;
            mask_q   <= mask1;
            wren_q   <= 1'b1;
            end_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= WB_BEAT0;
          end
        end
        WB_BEAT0: begin
          if (accept) begin
            if (single_q) begin
              wren_q  <= 1'b0;
              end_q   <= 1'b0;
              state_q <= WB_DONE;
            end else begin
              // wren/end stay high: beat 1 follows back-to-back
              data_q  <= dat2_q;
              mask_q  <= mask2_q;
              state_q <= WB_BEAT1;
            end
          end else if (to_hit) begin
            wren_q  <= 1'b0;
            end_q   <= 1'b0;
            state_q <= WB_DONE;
          end
        end
        WB_BEAT1: begin
          if (accept || to_hit) begin
            wren_q  <= 1'b0;
            end_q   <= 1'b0;
            state_q <= WB_DONE;
          end
        end
        WB_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= WB_IDLE;
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  always_comb begin
    wdf.app_wdf_data = data_q;
    wdf.app_wdf_mask = mask_q;
    wdf.app_wdf_wren = wren_q;
    wdf.app_wdf_end  = end_q;
    busy             = busy_q;
    done             = done_q;
    err              = err_q;
  end

endmodule

// File: tb/tb_mpmc11_wr_burst.sv
// tb_mpmc11_wr_burst -- directed self-checking bench for mpmc11_wr_burst.
// Build with MPMC11_WR_TIMEOUT_EN defined to exercise the timeout path
// (TO_CYCLES is overridden to 8).
module tb_mpmc11_wr_burst;

  localparam int unsigned WID = 256;
  localparam int unsigned MW  = WID / 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            single;
  logic [WID-1:0]  dat1;
  logic [WID-1:0]  dat2;
  logic [MW-1:0]   mask1;
  logic [MW-1:0]   mask2;
  logic            busy;
  logic            done;
  logic            err;

  int total;
  int bad;

  // accepted beats and done pulses, logged at negedge (stable inputs)
  logic [WID-1:0]  acc_data[$];
  logic [MW-1:0]   acc_mask[$];
  int              done_cnt;

  mpmc11_wr_burst_if #(.WID(WID)) wdf ();

  mpmc11_wr_burst #(
    .WID       (WID),
    .TO_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .single (single),
    .dat1   (dat1),
    .dat2   (dat2),
    .mask1  (mask1),
    .mask2  (mask2),
    .wdf    (wdf.master),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wdf.app_wdf_wren === 1'b1 && wdf.app_wdf_rdy === 1'b1) begin
        acc_data.push_back(wdf.app_wdf_data);
        acc_mask.push_back(wdf.app_wdf_mask);
      end
      if (done === 1'b1) done_cnt = done_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; single = 1'b0;
    dat1 = '0; dat2 = '0; mask1 = '0; mask2 = '0;
    wdf.app_wdf_rdy = 1'b1;
    step(); step();
    total++; if (wdf.app_wdf_wren !== 1'b0 || wdf.app_wdf_end !== 1'b0) begin bad++; $display("FAIL reset_wren_end got %b%b want 00", wdf.app_wdf_wren, wdf.app_wdf_end); end
    total++; if (wdf.app_wdf_data !== '0 || wdf.app_wdf_mask !== '0) begin bad++; $display("FAIL reset_data_mask got %h/%h want 0", wdf.app_wdf_data, wdf.app_wdf_mask); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_two_beat();
    int b0 = acc_data.size();
    int d0 = done_cnt;
    wdf.app_wdf_rdy = 1'b1;
    dat1 = {32{8'hA5}}; dat2 = {32{8'h5A}}; mask1 = '0; mask2 = '0;
    single = 1'b0; start = 1'b1;
    step();
    start = 1'b0; dat1 = {32{8'hEE}}; dat2 = {32{8'hDD}};
    total++; if (wdf.app_wdf_data !== {32{8'hA5}} || wdf.app_wdf_wren !== 1'b1 || wdf.app_wdf_end !== 1'b1) begin bad++; $display("FAIL two_beat0 got %h w%b e%b want a5.. w1 e1", wdf.app_wdf_data, wdf.app_wdf_wren, wdf.app_wdf_end); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL two_busy got %b want 1", busy); end
    step();
    total++; if (wdf.app_wdf_data !== {32{8'h5A}} || wdf.app_wdf_wren !== 1'b1 || wdf.app_wdf_end !== 1'b1) begin bad++; $display("FAIL two_beat1 got %h w%b e%b want 5a.. w1 e1", wdf.app_wdf_data, wdf.app_wdf_wren, wdf.app_wdf_end); end
    step();
    total++; if (wdf.app_wdf_wren !== 1'b0 || wdf.app_wdf_end !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL two_after got w%b e%b d%b want 000", wdf.app_wdf_wren, wdf.app_wdf_end, done); end
    total++; if (wdf.app_wdf_data !== {32{8'h5A}}) begin bad++; $display("FAIL two_retain got %h want 5a..", wdf.app_wdf_data); end
    step();
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL two_done got d%b b%b want d1 b0", done, busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL two_done_width got %b want 0", done); end
    total++; if (acc_data.size() - b0 != 2 || done_cnt - d0 != 1) begin bad++; $display("FAIL two_counts got beats=%0d dones=%0d want 2/1", acc_data.size() - b0, done_cnt - d0); end
    else if (acc_data[b0] !== {32{8'hA5}} || acc_data[b0+1] !== {32{8'h5A}}) begin bad++; $display("FAIL two_order got %h then %h", acc_data[b0], acc_data[b0+1]); end
  endtask

  task automatic test_single();
    int b0 = acc_data.size();
    int d0 = done_cnt;
    wdf.app_wdf_rdy = 1'b1;
    dat1 = {16{16'h1234}}; dat2 = {32{8'hFF}}; mask1 = 32'h0000_000F; mask2 = 32'hFFFF_0000;
    single = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    total++; if (wdf.app_wdf_mask !== 32'h0000_000F || wdf.app_wdf_data !== {16{16'h1234}}) begin bad++; $display("FAIL single_beat got %h/%h want 1234../0000000f", wdf.app_wdf_data, wdf.app_wdf_mask); end
    step();
    total++; if (wdf.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL single_wren_drop got %b want 0", wdf.app_wdf_wren); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got %b want 1", done); end
    step();
    total++; if (acc_data.size() - b0 != 1 || done_cnt - d0 != 1) begin bad++; $display("FAIL single_counts got beats=%0d dones=%0d want 1/1", acc_data.size() - b0, done_cnt - d0); end
    else if (acc_mask[b0] !== 32'h0000_000F) begin bad++; $display("FAIL single_mask_acc got %h want 0000000f", acc_mask[b0]); end
  endtask

  task automatic test_stall_beat1();
    int b0 = acc_data.size();
    int d0 = done_cnt;
    wdf.app_wdf_rdy = 1'b1;
    dat1 = {8{32'hCAFE_0001}}; dat2 = {8{32'hBEEF_0002}}; mask1 = 32'h1; mask2 = 32'h8000_0001;
    single = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    wdf.app_wdf_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (wdf.app_wdf_data !== {8{32'hBEEF_0002}} || wdf.app_wdf_mask !== 32'h8000_0001 || wdf.app_wdf_wren !== 1'b1 || wdf.app_wdf_end !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got %h/%h w%b e%b", i, wdf.app_wdf_data, wdf.app_wdf_mask, wdf.app_wdf_wren, wdf.app_wdf_end); end
    end
    wdf.app_wdf_rdy = 1'b1;
    step();
    total++; if (wdf.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL stall_accept got wren=%b want 0", wdf.app_wdf_wren); end
    step(); step();
    total++; if (acc_data.size() - b0 != 2 || done_cnt - d0 != 1) begin bad++; $display("FAIL stall_counts got beats=%0d dones=%0d want 2/1", acc_data.size() - b0, done_cnt - d0); end
    else if (acc_data[b0] !== {8{32'hCAFE_0001}} || acc_data[b0+1] !== {8{32'hBEEF_0002}}) begin bad++; $display("FAIL stall_order got %h then %h", acc_data[b0], acc_data[b0+1]); end
  endtask

  task automatic test_start_while_busy();
    int b0 = acc_data.size();
    int d0 = done_cnt;
    wdf.app_wdf_rdy = 1'b0;
    dat1 = {32{8'h11}}; dat2 = {32{8'h22}}; mask1 = '0; mask2 = '0;
    single = 1'b0; start = 1'b1;
    step();
    start = 1'b1; single = 1'b1; dat1 = {32{8'h99}}; dat2 = {32{8'h88}};
    step();
    start = 1'b0;
    total++; if (wdf.app_wdf_data !== {32{8'h11}} || wdf.app_wdf_wren !== 1'b1) begin bad++; $display("FAIL busy_start_ignored got %h w%b want 11.. w1", wdf.app_wdf_data, wdf.app_wdf_wren); end
    wdf.app_wdf_rdy = 1'b1;
    step();
    total++; if (wdf.app_wdf_data !== {32{8'h22}}) begin bad++; $display("FAIL busy_beat1 got %h want 22..", wdf.app_wdf_data); end
    step(); step(); step(); step();
    total++; if (acc_data.size() - b0 != 2 || done_cnt - d0 != 1 || busy !== 1'b0) begin bad++; $display("FAIL busy_counts got beats=%0d dones=%0d busy=%b want 2/1/0", acc_data.size() - b0, done_cnt - d0, busy); end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    int b0;
    wdf.app_wdf_rdy = 1'b1;
    dat1 = {32{8'h33}}; dat2 = {32{8'h44}}; mask1 = 32'hF; mask2 = 32'hF0;
    single = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    wdf.app_wdf_rdy = 1'b0;
    step();
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    total++; if (wdf.app_wdf_wren !== 1'b0 || wdf.app_wdf_end !== 1'b0 || wdf.app_wdf_data !== '0 || wdf.app_wdf_mask !== '0 || {busy, done, err} !== 3'b000) begin bad++; $display("FAIL rst_async got w%b e%b d=%h m=%h f=%b want all 0", wdf.app_wdf_wren, wdf.app_wdf_end, wdf.app_wdf_data, wdf.app_wdf_mask, {busy, done, err}); end
    step(); step();
    rst_n = 1'b1;
    wdf.app_wdf_rdy = 1'b1;
    step(); step();
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rst_no_done got dones=%0d want %0d", done_cnt, d0); end
    b0 = acc_data.size();
    dat1 = {32{8'h77}}; mask1 = 32'h3; single = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    total++; if (acc_data.size() - b0 != 1 || done_cnt - d0 != 1) begin bad++; $display("FAIL rst_restart got beats=%0d dones=%0d want 1/1", acc_data.size() - b0, done_cnt - d0); end
    else if (acc_data[b0] !== {32{8'h77}}) begin bad++; $display("FAIL rst_restart_data got %h want 77..", acc_data[b0]); end
  endtask

`ifdef MPMC11_WR_TIMEOUT_EN
  task automatic test_timeout();
    int b0 = acc_data.size();
    int d0 = done_cnt;
    wdf.app_wdf_rdy = 1'b0;
    dat1 = {32{8'hAB}}; dat2 = {32{8'hCD}}; single = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      total++; if (err !== 1'b0 || wdf.app_wdf_wren !== 1'b1) begin bad++; $display("FAIL to_pre%0d got err=%b wren=%b want 0/1", k, err, wdf.app_wdf_wren); end
    end
    step();
    total++; if (err !== 1'b1 || wdf.app_wdf_wren !== 1'b0 || wdf.app_wdf_end !== 1'b0) begin bad++; $display("FAIL to_hit got err=%b wren=%b end=%b want 1/0/0", err, wdf.app_wdf_wren, wdf.app_wdf_end); end
    step();
    total++; if (done !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL to_done got done=%b err=%b want 1/1", done, err); end
    step(); step();
    total++; if (err !== 1'b1 || acc_data.size() != b0 || done_cnt - d0 != 1) begin bad++; $display("FAIL to_sticky got err=%b beats=%0d dones=%0d want 1/0/1", err, acc_data.size() - b0, done_cnt - d0); end
    wdf.app_wdf_rdy = 1'b1; single = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    total++; if (err !== 1'b0 || wdf.app_wdf_wren !== 1'b1) begin bad++; $display("FAIL to_clear got err=%b wren=%b want 0/1", err, wdf.app_wdf_wren); end
    step(); step(); step();
  endtask
`else
  task automatic test_no_timeout();
    int b0 = acc_data.size();
    int d0 = done_cnt;
    wdf.app_wdf_rdy = 1'b0;
    dat1 = {32{8'h5C}}; single = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 300; k++) step();
    total++; if (err !== 1'b0 || wdf.app_wdf_wren !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL nto_wait got err=%b wren=%b busy=%b want 0/1/1", err, wdf.app_wdf_wren, busy); end
    wdf.app_wdf_rdy = 1'b1;
    step(); step(); step();
    total++; if (acc_data.size() - b0 != 1 || done_cnt - d0 != 1 || err !== 1'b0) begin bad++; $display("FAIL nto_finish got beats=%0d dones=%0d err=%b want 1/1/0", acc_data.size() - b0, done_cnt - d0, err); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_two_beat();
    test_single();
    test_stall_beat1();
    test_start_while_busy();
    test_reset_mid_burst();
`ifdef MPMC11_WR_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
